path_delay_monitor: RTL and testbench

Active launch-and-capture monitor for a single combinational delay path under test. It drives the path's input net and samples the path's output net. Each run launches one rising and one falling transition, counts clock cycles until the synchronized output reaches the expected value, and flags an alarm when either delay exceeds a programmable threshold. It sits directly upstream and downstream of a delay path: it feeds the path input and consumes the path output.

---
 rtl/path_delay_monitor_pkg.sv | 18 +
 rtl/path_delay_monitor_if.sv | 25 ++
 rtl/path_sync_2ff.sv | 23 ++
 rtl/path_delay_monitor.sv | 162 ++++++++++++++++
 tb/tb_path_delay_monitor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/path_delay_monitor_pkg.sv
// Shared types and constants for the path delay monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package path_mon_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_LO = 3'd1,
    RISE   = 3'd2,
    PRE_HI = 3'd3,
    FALL   = 3'd4,
    REPORT = 3'd5
  } state_t;

  // Depth of the path_out synchronizer; also the delay a zero-delay path reports.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/path_delay_monitor_if.sv
// Control/result bundle between a run requester and the path delay monitor.
// Latency: n/a (wires only).
// Backpressure: start is ignored while busy; results hold until the next done.
interface path_delay_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] threshold;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] delay_rise;
  logic [CNT_W-1:0] delay_fall;
  logic             alarm;
  logic             timeout;

  modport master (
    output start, threshold,
    input  busy, done, delay_rise, delay_fall, alarm, timeout
  );

  modport slave (
    input  start, threshold,
    output busy, done, delay_rise, delay_fall, alarm, timeout
  );
endinterface

// File: rtl/path_sync_2ff.sv
// Brings the asynchronous path output into the clk domain.
// Latency: SYNC_STAGES (2) cycles.
// Backpressure: none.
module path_sync_2ff
  import path_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift the raw input through the synchronizer chain; clears to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_monitor.sv
// Launches a rise then a fall into the path under test and times each arrival.
// Latency: 2*SETTLE + 2*(delay+2) + 2 cycles from accepted start to done on a clean path.
// Backpressure: start accepted only in IDLE; results hold until the next done pulse.
module path_delay_monitor
  import path_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int SETTLE  = 4,
  parameter int EXP_INV = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  path_delay_monitor_if.slave  ctl,
  output logic                 path_in,
  input  logic                 path_out
);

  localparam int               SET_W       = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic             INV         = (EXP_INV != 0);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [SET_W-1:0]   scnt, scnt_nx;
  logic               to_flag, to_nx;
  logic [CNT_W-1:0]   rise_q, rise_nx;
  logic [CNT_W-1:0]   thr_q;
  logic               path_in_nx;
  logic               report_ld;
  logic [CNT_W-1:0]   fall_val;
  logic [CNT_W-1:0]   worst;
  logic               sync_out;
  logic               match;

  logic               done_q, alarm_q, timeout_q;
  logic [CNT_W-1:0]   delay_rise_q, delay_fall_q;

  path_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (path_out),
    .q     (sync_out)
  );

  // The path has "arrived" when the synchronized output matches the driven level.
  assign match = (sync_out == (path_in ^ INV));

  // State, counters and per-run scratch; reset aborts a run with path_in low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      scnt    <= '0;
      to_flag <= 1'b0;
      rise_q  <= '0;
      thr_q   <= '0;
      path_in <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      scnt    <= scnt_nx;
      to_flag <= to_nx;
      rise_q  <= rise_nx;
      path_in <= path_in_nx;
      if (state == IDLE && ctl.start) thr_q <= ctl.threshold;
    end
  end

  // Next-state logic: settle windows, measurement phases and timeout handling.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    scnt_nx   = scnt;
    to_nx     = to_flag;
    rise_nx   = rise_q;
    report_ld = 1'b0;
    fall_val  = '0;
    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          state_nx = PRE_LO;
          cnt_nx   = '0;
          scnt_nx  = '0;
          to_nx    = 1'b0;
          rise_nx  = '0;
        end
      end
      PRE_LO, PRE_HI: begin
        // A mismatch anywhere in the window restarts the settle count.
        if ((match && scnt == SETTLE_LAST) || cnt == TIMEOUT_C) begin
          if (!(match && scnt == SETTLE_LAST)) to_nx = 1'b1;
          state_nx = (state == PRE_LO) ? RISE : FALL;
          cnt_nx   = '0;
          scnt_nx  = '0;
        end else begin
          cnt_nx  = cnt + CNT_W'(1);
          scnt_nx = match ? scnt + SET_W'(1) : '0;
        end
      end
      RISE: begin
        if (match || cnt == TIMEOUT_C) begin
          if (!match) to_nx = 1'b1;
          rise_nx  = cnt;
          state_nx = PRE_HI;
          cnt_nx   = '0;
          scnt_nx  = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      FALL: begin
        if (match || cnt == TIMEOUT_C) begin
          if (!match) to_nx = 1'b1;
          fall_val  = cnt;
          report_ld = 1'b1;
          state_nx  = REPORT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drive the path high only while launching or holding the rising level.
  always_comb begin
    path_in_nx = 1'b0;
    if (state_nx == RISE || state_nx == PRE_HI) path_in_nx = 1'b1;
  end

  assign worst = (rise_q > fall_val) ? rise_q : fall_val;

  // Results load on the edge into REPORT so done and the values appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      delay_rise_q <= '0;
      delay_fall_q <= '0;
      alarm_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q <= report_ld;
      if (report_ld) begin
        delay_rise_q <= rise_q;
        delay_fall_q <= fall_val;
        timeout_q    <= to_nx;
        alarm_q      <= to_nx | (worst > thr_q);
      end
    end
  end

  assign ctl.busy       = (state != IDLE);
  assign ctl.done       = done_q;
  assign ctl.delay_rise = delay_rise_q;
  assign ctl.delay_fall = delay_fall_q;
  assign ctl.alarm      = alarm_q;
  assign ctl.timeout    = timeout_q;

endmodule

// File: tb/tb_path_delay_monitor.sv
// Directed bench: loopback, delayed, stuck and inverting paths plus reset abort.
// Latency: checks exact start-to-done cycle counts per run.
// Backpressure: exercises starts issued while busy and on the done cycle.
module tb_path_delay_monitor;

  localparam int RISE_D = 10;
  localparam int FALL_D = 14;

  localparam int M_LOOP  = 0;
  localparam int M_DELAY = 1;
  localparam int M_STUCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_delay_monitor_if #(.CNT_W(8)) ifc ();
  path_delay_monitor_if #(.CNT_W(8)) ifc_inv ();

  logic pin_m, pout_m, pin_i, pout_i;

  logic       start_b = 1'b0;
  logic [7:0] thr_b = 8'd0;
  logic       use_inv = 1'b0;
  int         mode = M_LOOP;
  logic       glitch = 1'b0;
  logic       model_out = 1'b0;

  assign ifc.start         = start_b & ~use_inv;
  assign ifc.threshold     = thr_b;
  assign ifc_inv.start     = start_b & use_inv;
  assign ifc_inv.threshold = thr_b;

  assign pout_m = (mode == M_STUCK) ? 1'b0 :
                  (mode == M_DELAY) ? model_out : (pin_m & ~glitch);
  assign pout_i = ~pin_i;

  path_delay_monitor #(.CNT_W(8), .TIMEOUT(200), .SETTLE(4), .EXP_INV(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (ifc.slave),
    .path_in  (pin_m),
    .path_out (pout_m)
  );

  path_delay_monitor #(.CNT_W(8), .TIMEOUT(200), .SETTLE(4), .EXP_INV(1)) dut_inv (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (ifc_inv.slave),
    .path_in  (pin_i),
    .path_out (pout_i)
  );

  // Selected-DUT views
  logic       s_done, s_busy, s_alarm, s_to, s_pin;
  logic [7:0] s_rise, s_fall;
  assign s_done  = use_inv ? ifc_inv.done       : ifc.done;
  assign s_busy  = use_inv ? ifc_inv.busy       : ifc.busy;
  assign s_alarm = use_inv ? ifc_inv.alarm      : ifc.alarm;
  assign s_to    = use_inv ? ifc_inv.timeout    : ifc.timeout;
  assign s_rise  = use_inv ? ifc_inv.delay_rise : ifc.delay_rise;
  assign s_fall  = use_inv ? ifc_inv.delay_fall : ifc.delay_fall;
  assign s_pin   = use_inv ? pin_i              : pin_m;

  // Path delay model: output follows path_in RISE_D/FALL_D cycles after it moves.
  logic m_last = 1'b0;
  int   m_age = 1000;
  always begin
    @(posedge clk);
    #1;
    if (pin_m !== m_last) begin
      m_last = pin_m;
      m_age  = 0;
    end else if (m_age < 1000) begin
      m_age++;
    end
    if (m_last && m_age == RISE_D) model_out = 1'b1;
    if (!m_last && m_age == FALL_D) model_out = 1'b0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    int inv;
    int thr;
    int glitch_at;
    int e_rise;
    int e_fall;
    int e_alarm;
    int e_to;
    int e_lat;
  } vec_t;

  vec_t vecs[7];
  int p_rise = 0, p_fall = 0, p_alarm = 0, p_to = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input bit poke, input string tag);
    int k;
    mode    = v.mode;
    use_inv = v.inv[0];
    thr_b   = v.thr[7:0];
    glitch  = 1'b0;
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    thr_b   = ~v.thr[7:0];
    k = 0;
    check({tag, " busy_after_start"}, s_busy, 1);
    while (s_done !== 1'b1 && k < 600) begin
      if (k == 5 && v.inv == 0) begin
        check({tag, " hold_rise"}, s_rise, p_rise);
        check({tag, " hold_fall"}, s_fall, p_fall);
        check({tag, " hold_alarm"}, s_alarm, p_alarm);
        check({tag, " hold_timeout"}, s_to, p_to);
      end
      if (poke) start_b = k[0];
      step();
      k++;
      if (k == v.glitch_at) glitch = 1'b1;
      if (k == v.glitch_at + 2) glitch = 1'b0;
    end
    check({tag, " latency"}, k, v.e_lat);
    check({tag, " delay_rise"}, s_rise, v.e_rise);
    check({tag, " delay_fall"}, s_fall, v.e_fall);
    check({tag, " alarm"}, s_alarm, v.e_alarm);
    check({tag, " timeout"}, s_to, v.e_to);
    check({tag, " busy_at_done"}, s_busy, 1);
    if (poke) start_b = 1'b1;
    step();
    start_b = 1'b0;
    check({tag, " done_one_cycle"}, s_done, 0);
    check({tag, " idle_after_done"}, s_busy, 0);
    if (v.inv == 0) begin
      p_rise = v.e_rise; p_fall = v.e_fall; p_alarm = v.e_alarm; p_to = v.e_to;
    end
    repeat (30) step();
  endtask

  initial begin
    int ndone;
    //          mode     inv thr  glitch rise fall al to lat
    vecs[0] = '{M_LOOP,  0,  5,   -10,   2,   2,   0, 0, 14};
    vecs[1] = '{M_DELAY, 0,  12,  -10,   12,  16,  1, 0, 38};
    vecs[2] = '{M_DELAY, 0,  16,  -10,   12,  16,  0, 0, 38};
    vecs[3] = '{M_DELAY, 0,  15,  -10,   12,  16,  1, 0, 38};
    vecs[4] = '{M_STUCK, 0,  250, -10,   200, 0,   1, 1, 407};
    vecs[5] = '{M_LOOP,  1,  2,   -10,   2,   2,   0, 0, 14};
    vecs[6] = '{M_LOOP,  0,  5,   7,     2,   2,   0, 0, 18};

    repeat (3) @(posedge clk);
    #1;
    check("reset path_in", pin_m, 0);
    check("reset busy", ifc.busy, 0);
    check("reset done", ifc.done, 0);
    check("reset rise", ifc.delay_rise, 0);
    check("reset fall", ifc.delay_fall, 0);
    check("reset alarm", ifc.alarm, 0);
    check("reset timeout", ifc.timeout, 0);
    rst_n = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Starts hammered while busy and on the done cycle must not disturb the run.
    run_vec(vecs[1], 1'b1, "poke");

    // Reset during the falling measurement aborts the run.
    mode    = M_DELAY;
    use_inv = 1'b0;
    thr_b   = 8'd12;
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (25) step();
    check("abort in_fall busy", ifc.busy, 1);
    check("abort in_fall path_in", pin_m, 0);
    rst_n = 1'b0;
    #1;
    check("abort path_in", pin_m, 0);
    check("abort busy", ifc.busy, 0);
    check("abort done", ifc.done, 0);
    check("abort rise", ifc.delay_rise, 0);
    check("abort fall", ifc.delay_fall, 0);
    check("abort alarm", ifc.alarm, 0);
    check("abort timeout", ifc.timeout, 0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (ifc.done === 1'b1) ndone++;
    end
    check("abort no_done", ndone, 0);
    check("abort stays_idle", ifc.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
